// File: rtl/banked_reg_file_if.sv
// banked_reg_file_if: register-file access bundle (read ports, two write ports,
// PC update, SPSR access, error flag). The master drives addresses and write
// data; the slave (the register file) returns read data, spsr and err.
interface banked_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 3
);
    logic [4:0]               mode;
    logic [NUM_RD*4-1:0]      addrR;
    logic [NUM_RD*DATA_W-1:0] dataR;
    logic [3:0]               addrW0;
    logic [3:0]               addrW1;
    logic [DATA_W-1:0]        dataW0;
    logic [DATA_W-1:0]        dataW1;
    logic                     regW0;
    logic                     regW1;
    logic [DATA_W-1:0]        dataPC;
    logic                     regPC;
    logic [DATA_W-1:0]        dataSPSR;
    logic                     regSPSR;
    logic [DATA_W-1:0]        spsr;
    logic                     err;

    modport master (
        output mode, addrR, addrW0, addrW1, dataW0, dataW1, regW0, regW1,
               dataPC, regPC, dataSPSR, regSPSR,
        input  dataR, spsr, err
    );

    modport slave (
        input  mode, addrR, addrW0, addrW1, dataW0, dataW1, regW0, regW1,
               dataPC, regPC, dataSPSR, regSPSR,
        output dataR, spsr, err
    );
endinterface

// File: rtl/banked_reg_file.sv
// banked_reg_file: ARM-style mode-banked register file.
//   - 31 physical registers: r0-r15 common (r15 = PC), FIQ r8-r14, and
//     r13-r14 for each of IRQ, SVC, ABT and UND. USR and SYS use the common set.
//   - One SPSR per exception mode (FIQ, IRQ, SVC, ABT, UND).
//   - NUM_RD combinational read ports, two write ports (W1 beats W0), PC port.
//   - Invalid modes suppress every write and force all read data to zero.
//   - err is a registered flag raised one edge after a faulty cycle.
// Optional build macro:
//   BANKED_RF_BYPASS_EN - read ports forward the data being written this cycle
//                         (W1 over W0 over PC). Undefined: stored values only.
// DATA_W and NUM_RD must match the parameters of the connected interface.
module banked_reg_file #(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 3
) (
    input logic              CP,
    input logic              reset,
    banked_reg_file_if.slave bus
);

    localparam int         NUM_PHYS = 31;
    localparam int         NUM_SPSR = 5;
    localparam logic [4:0] PC_IDX   = 5'd15;

    // Physical-bank selector derived from the 5-bit mode field.
    typedef enum logic [2:0] {
        BANK_USR, // USR and SYS share the common set and have no SPSR
        BANK_FIQ,
        BANK_IRQ,
        BANK_SVC,
        BANK_ABT,
        BANK_UND,
        BANK_INV
    } bankT;

    // Physical layout:
    //   0..14  common r0-r14
    //   15     PC
    //   16..22 FIQ r8-r14
    //   23/24  IRQ r13/r14, 25/26 SVC, 27/28 ABT, 29/30 UND
    logic [DATA_W-1:0] physRegs [NUM_PHYS];
    logic [DATA_W-1:0] spsrRegs [NUM_SPSR];
    logic              errQ;

    bankT              curBank;
    logic              bankValid;
    logic              hasSpsr;
    logic [2:0]        spsrIdx;
    logic [4:0]        wIdx0;
    logic [4:0]        wIdx1;
    logic              errNext;
    logic [4:0]        rdIdx;
    logic [DATA_W-1:0] rdWord;
    logic [NUM_RD*DATA_W-1:0] dataRFlat;

    function automatic bankT decodeMode(input logic [4:0] mode);
        bankT bank;
        case (mode)
            5'b10000: bank = BANK_USR;
            5'b11111: bank = BANK_USR;
            5'b10001: bank = BANK_FIQ;
            5'b10010: bank = BANK_IRQ;
            5'b10011: bank = BANK_SVC;
            5'b10111: bank = BANK_ABT;
            5'b11011: bank = BANK_UND;
            default:  bank = BANK_INV;
        endcase
        return bank;
    endfunction

    // Map an architectural address to its physical slot for a given bank.
    function automatic logic [4:0] physIndex(input bankT bank, input logic [3:0] addr);
        logic [4:0] idx;
        logic       isSpLr;
        logic [4:0] spLrBase;
        idx      = {1'b0, addr};
        isSpLr   = (addr == 4'd13) || (addr == 4'd14);
        spLrBase = 5'd0;
        case (bank)
            BANK_IRQ: spLrBase = 5'd23;
            BANK_SVC: spLrBase = 5'd25;
            BANK_ABT: spLrBase = 5'd27;
            BANK_UND: spLrBase = 5'd29;
            default:  spLrBase = 5'd0;
        endcase
        if (bank == BANK_FIQ) begin
            if (addr >= 4'd8 && addr <= 4'd14) begin
                idx = {1'b0, addr} + 5'd8;
            end
        end else if (spLrBase != 5'd0 && isSpLr) begin
            // r13 has addr[0]=1 -> base, r14 has addr[0]=0 -> base+1
            idx = spLrBase + {4'b0, ~addr[0]};
        end
        return idx;
    endfunction

    function automatic logic [2:0] spsrSlot(input bankT bank);
        logic [2:0] slot;
        case (bank)
            BANK_FIQ: slot = 3'd0;
            BANK_IRQ: slot = 3'd1;
            BANK_SVC: slot = 3'd2;
            BANK_ABT: slot = 3'd3;
            BANK_UND: slot = 3'd4;
            default:  slot = 3'd0;
        endcase
        return slot;
    endfunction

    // Decode the current mode and the physical targets of both write ports.
    // NOTE: every variable written in always_comb is assigned on every path,
    // so no latch can be inferred.
    always_comb begin : modeDecode
        curBank   = decodeMode(bus.mode);
        bankValid = (curBank != BANK_INV);
        hasSpsr   = bankValid && (curBank != BANK_USR);
        spsrIdx   = spsrSlot(curBank);
        wIdx0     = physIndex(curBank, bus.addrW0);
        wIdx1     = physIndex(curBank, bus.addrW1);
        errNext   = !bankValid
                  || (bus.regW0 && bus.regW1 && (bus.addrW0 == bus.addrW1))
                  || (bus.regSPSR && (curBank == BANK_USR));
    end

    // Register, SPSR and error-flag update on the rising clock edge.
    // NOTE: sequential state uses non-blocking assignments; within one block
    // the last scheduled write to a slot wins, which is how W1 > W0 > PC is
    // expressed below.
    // NOTE: the register array is reset deliberately: software expects every
    // bank, the PC and every SPSR to read as zero after reset.
    always_ff @(posedge CP) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                physRegs[i] <= '0;
            end
            for (int i = 0; i < NUM_SPSR; i++) begin
                spsrRegs[i] <= '0;
            end
            errQ <= 1'b0;
        end else begin
            if (bankValid) begin
                if (bus.regPC) begin
                    physRegs[PC_IDX] <= bus.dataPC;
                end
                if (bus.regW0) begin
                    physRegs[wIdx0] <= bus.dataW0;
                end
                if (bus.regW1) begin
                    physRegs[wIdx1] <= bus.dataW1;
                end
                if (bus.regSPSR && hasSpsr) begin
                    spsrRegs[spsrIdx] <= bus.dataSPSR;
                end
            end
            errQ <= errNext;
        end
    end

    // Combinational read ports; zero while in reset or in an invalid mode.
    always_comb begin : readMux
        dataRFlat = '0;
        rdIdx     = '0;
        rdWord    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rdIdx  = physIndex(curBank, bus.addrR[4*i +: 4]);
            rdWord = physRegs[rdIdx];
`ifdef BANKED_RF_BYPASS_EN
            // Forward the value that will win at the next edge.
            if (bus.regW1 && (wIdx1 == rdIdx)) begin
                rdWord = bus.dataW1;
            end else if (bus.regW0 && (wIdx0 == rdIdx)) begin
                rdWord = bus.dataW0;
            end else if (bus.regPC && (rdIdx == PC_IDX)) begin
                rdWord = bus.dataPC;
            end
`endif
            if (!reset && bankValid) begin
                dataRFlat[DATA_W*i +: DATA_W] = rdWord;
            end
        end
    end

    assign bus.dataR = dataRFlat;
    assign bus.spsr  = (!reset && hasSpsr) ? spsrRegs[spsrIdx] : '0;
    assign bus.err   = errQ;

endmodule

// File: tb/tb_banked_reg_file.sv
// tb_banked_reg_file: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a string-keyed reference model.
module tb_banked_reg_file;

    localparam int DW = 32;
    localparam int NR = 3;

    logic CP = 1'b0;
    logic reset = 1'b1;

    always #5 CP = ~CP;

    banked_reg_file_if #(.DATA_W(DW), .NUM_RD(NR)) bus ();

    banked_reg_file #(.DATA_W(DW), .NUM_RD(NR)) dut (
        .CP   (CP),
        .reset(reset),
        .bus  (bus)
    );

    localparam logic [4:0] M_USR = 5'b10000, M_FIQ = 5'b10001, M_IRQ = 5'b10010,
                           M_SVC = 5'b10011, M_ABT = 5'b10111, M_UND = 5'b11011,
                           M_SYS = 5'b11111, M_BAD = 5'b11010;

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdPort(input int i);
        return bus.dataR[DW*i +: DW];
    endfunction

    task automatic idleInputs();
        bus.regW0 = 0; bus.addrW0 = 0; bus.dataW0 = 0;
        bus.regW1 = 0; bus.addrW1 = 0; bus.dataW1 = 0;
        bus.regPC = 0; bus.dataPC = 0;
        bus.regSPSR = 0; bus.dataSPSR = 0;
    endtask

    // ---------------- reference model (architectural view) ----------------
    logic [31:0] mdlReg  [string];
    logic [31:0] mdlSpsr [string];

    function automatic string modeName(input logic [4:0] m);
        case (m)
            M_USR: return "usr";
            M_FIQ: return "fiq";
            M_IRQ: return "irq";
            M_SVC: return "svc";
            M_ABT: return "abt";
            M_UND: return "und";
            M_SYS: return "sys";
            default: return "";
        endcase
    endfunction

    function automatic bit ownsSpsr(input string n);
        return n != "" && n != "usr" && n != "sys";
    endfunction

    // Which storage a register name refers to in a given mode.
    function automatic string regKey(input logic [4:0] m, input logic [3:0] r);
        string n;
        n = modeName(m);
        if (r == 4'd15) return "pc";
        if (n == "fiq" && r >= 4'd8) return $sformatf("fiq.r%0d", r);
        if (ownsSpsr(n) && r >= 4'd13) return $sformatf("%s.r%0d", n, r);
        return $sformatf("common.r%0d", r);
    endfunction

    function automatic logic [31:0] mdlGet(input string k);
        return mdlReg.exists(k) ? mdlReg[k] : 32'd0;
    endfunction

    function automatic logic [31:0] expRead(input int i);
        string k;
        if (reset || modeName(bus.mode) == "") return 32'd0;
        k = regKey(bus.mode, bus.addrR[4*i +: 4]);
`ifdef BANKED_RF_BYPASS_EN
        if (bus.regW1 && regKey(bus.mode, bus.addrW1) == k) return bus.dataW1;
        if (bus.regW0 && regKey(bus.mode, bus.addrW0) == k) return bus.dataW0;
        if (bus.regPC && k == "pc") return bus.dataPC;
`endif
        return mdlGet(k);
    endfunction

    function automatic logic [31:0] expSpsr();
        string n;
        n = modeName(bus.mode);
        if (reset || !ownsSpsr(n)) return 32'd0;
        return mdlSpsr.exists(n) ? mdlSpsr[n] : 32'd0;
    endfunction

    function automatic logic expErr();
        string n;
        n = modeName(bus.mode);
        return (n == "")
            || (bus.regW0 && bus.regW1 && bus.addrW0 == bus.addrW1)
            || (bus.regSPSR && (n == "usr" || n == "sys"));
    endfunction

    task automatic mdlCommit();
        string n;
        n = modeName(bus.mode);
        if (reset) begin
            mdlReg.delete();
            mdlSpsr.delete();
        end else if (n != "") begin
            if (bus.regPC) mdlReg["pc"] = bus.dataPC;
            if (bus.regW0) mdlReg[regKey(bus.mode, bus.addrW0)] = bus.dataW0;
            if (bus.regW1) mdlReg[regKey(bus.mode, bus.addrW1)] = bus.dataW1;
            if (bus.regSPSR && ownsSpsr(n)) mdlSpsr[n] = bus.dataSPSR;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic [4:0]  mode;
        logic        w0; logic [3:0] a0; logic [31:0] d0;
        logic        w1; logic [3:0] a1; logic [31:0] d1;
        logic        pc; logic [31:0] dpc;
        logic        sp; logic [31:0] dsp;
        logic [3:0]  ra [3];
        logic [31:0] er [3];
        logic [31:0] espsr;
        logic        eerr;
    } vecT;

    vecT vecs[$];

    task automatic addVec(input string name, input logic [4:0] mode,
                          input logic w0, input logic [3:0] a0, input logic [31:0] d0,
                          input logic w1, input logic [3:0] a1, input logic [31:0] d1,
                          input logic pc, input logic [31:0] dpc,
                          input logic sp, input logic [31:0] dsp,
                          input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] espsr, input logic eerr);
        vecT v;
        v.name = name; v.mode = mode;
        v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.pc = pc; v.dpc = dpc; v.sp = sp; v.dsp = dsp;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
        v.er[0] = e0; v.er[1] = e1; v.er[2] = e2;
        v.espsr = espsr; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic applyVec(input vecT v);
        bus.mode = v.mode;
        bus.regW0 = v.w0; bus.addrW0 = v.a0; bus.dataW0 = v.d0;
        bus.regW1 = v.w1; bus.addrW1 = v.a1; bus.dataW1 = v.d1;
        bus.regPC = v.pc; bus.dataPC = v.dpc;
        bus.regSPSR = v.sp; bus.dataSPSR = v.dsp;
        bus.addrR = {v.ra[2], v.ra[1], v.ra[0]};
    endtask

    logic [4:0] validModes [7];
    logic [4:0] m;
    logic       eErr;

    initial begin
        validModes = '{M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND, M_SYS};

        //     name         mode   w0 a0  d0      w1 a1  d1      pc dpc  sp dsp     ra0 ra1 ra2  er0      er1  er2  spsr     err
        addVec("usr_r0",    M_USR, 1, 0,  123,    0, 0,  0,      0, 0,   0, 0,      0,  8,  15,  123,     0,   0,   0,       0);
        addVec("usr_r8",    M_USR, 1, 8,  456,    0, 0,  0,      0, 0,   0, 0,      0,  8,  15,  123,     456, 0,   0,       0);
        addVec("fiq_r8",    M_FIQ, 1, 8,  789,    0, 0,  0,      0, 0,   0, 0,      8,  0,  13,  789,     123, 0,   0,       0);
        addVec("usr_back",  M_USR, 0, 0,  0,      0, 0,  0,      0, 0,   0, 0,      8,  0,  15,  456,     123, 0,   0,       0);
        addVec("pc_w0win",  M_USR, 1, 15, 333,    0, 0,  0,      1, 25,  0, 0,      15, 8,  0,   333,     456, 123, 0,       0);
        addVec("pc_only",   M_USR, 0, 0,  0,      0, 0,  0,      1, 26,  0, 0,      15, 8,  0,   26,      456, 123, 0,       0);
        addVec("bad_mode",  M_BAD, 1, 14, 123,    0, 0,  0,      0, 0,   0, 0,      14, 0,  8,   0,       0,   0,   0,       1);
        addVec("err_clear", M_USR, 0, 0,  0,      0, 0,  0,      0, 0,   0, 0,      14, 0,  8,   0,       123, 456, 0,       0);
        addVec("w1_wins",   M_USR, 1, 3,  111,    1, 3,  222,    0, 0,   0, 0,      3,  0,  8,   222,     123, 456, 0,       1);
        addVec("w1_after",  M_USR, 0, 0,  0,      0, 0,  0,      0, 0,   0, 0,      3,  0,  8,   222,     123, 456, 0,       0);
        addVec("svc_spsr",  M_SVC, 0, 0,  0,      0, 0,  0,      0, 0,   1, 32'h1D3, 13, 14, 3,   0,       0,   222, 32'h1D3, 0);
        addVec("irq_spsr",  M_IRQ, 0, 0,  0,      0, 0,  0,      0, 0,   0, 0,      13, 14, 3,   0,       0,   222, 0,       0);
        addVec("svc_again", M_SVC, 0, 0,  0,      0, 0,  0,      0, 0,   0, 0,      13, 14, 3,   0,       0,   222, 32'h1D3, 0);
        addVec("usr_spsrw", M_USR, 0, 0,  0,      0, 0,  0,      0, 0,   1, 32'h55, 13, 14, 3,   0,       0,   222, 0,       1);
        addVec("svc_r13",   M_SVC, 0, 0,  0,      1, 13, 32'hAAAA, 0, 0, 0, 0,      13, 14, 0,   32'hAAAA, 0,  123, 32'h1D3, 0);
        addVec("sys_view",  M_SYS, 0, 0,  0,      0, 0,  0,      0, 0,   0, 0,      13, 15, 8,   0,       26,  456, 0,       0);
        addVec("und_spsr",  M_UND, 1, 14, 32'h77, 0, 0,  0,      0, 0,   1, 32'h1F, 14, 13, 8,   32'h77,  0,   456, 32'h1F,  0);
        addVec("abt_view",  M_ABT, 0, 0,  0,      0, 0,  0,      0, 0,   0, 0,      14, 13, 15,  0,       0,   26,  0,       0);

        // Reset state
        bus.mode = M_USR;
        bus.addrR = {4'd2, 4'd1, 4'd0};
        idleInputs();
        reset = 1'b1;
        repeat (2) @(posedge CP);
        #1;
        for (int i = 0; i < NR; i++) check($sformatf("reset_dataR%0d", i), rdPort(i), 32'd0);
        check("reset_spsr", bus.spsr, 32'd0);
        check("reset_err", {31'd0, bus.err}, 32'd0);
        reset = 1'b0;

        // Directed table: apply at posedge+1, check after the next edge
        foreach (vecs[k]) begin
            applyVec(vecs[k]);
            @(posedge CP);
            #1;
            for (int i = 0; i < NR; i++)
                check($sformatf("%s_dataR%0d", vecs[k].name, i), rdPort(i), vecs[k].er[i]);
            check({vecs[k].name, "_spsr"}, bus.spsr, vecs[k].espsr);
            check({vecs[k].name, "_err"}, {31'd0, bus.err}, {31'd0, vecs[k].eerr});
        end

        // Same-address W0/W1 collision seen within the write cycle
        idleInputs();
        bus.mode = M_USR;
        bus.addrR = {4'd4, 4'd4, 4'd4};
        bus.regW0 = 1; bus.addrW0 = 4; bus.dataW0 = 111;
        bus.regW1 = 1; bus.addrW1 = 4; bus.dataW1 = 222;
        #2;
`ifdef BANKED_RF_BYPASS_EN
        check("collide_same_cycle", rdPort(0), 32'd222);
`else
        check("collide_same_cycle", rdPort(0), 32'd0);
`endif
        @(posedge CP);
        #1;
        check("collide_after", rdPort(0), 32'd222);
        check("collide_err", {31'd0, bus.err}, 32'd1);

        // Reset overrides writes and clears banks, PC, SPSRs and err
        reset = 1'b1;
        idleInputs();
        bus.mode = M_SVC;
        bus.addrR = {4'd13, 4'd1, 4'd15};
        bus.regW0 = 1; bus.addrW0 = 1; bus.dataW0 = 32'hDEAD;
        bus.regPC = 1; bus.dataPC = 77;
        bus.regSPSR = 1; bus.dataSPSR = 32'h99;
        @(posedge CP);
        #1;
        for (int i = 0; i < NR; i++) check($sformatf("rst_hold_dataR%0d", i), rdPort(i), 32'd0);
        check("rst_hold_spsr", bus.spsr, 32'd0);
        check("rst_hold_err", {31'd0, bus.err}, 32'd0);
        @(posedge CP);
        #1;
        reset = 1'b0;
        idleInputs();
        bus.addrR = {4'd13, 4'd0, 4'd15};
        @(posedge CP);
        #1;
        for (int i = 0; i < NR; i++) check($sformatf("post_rst_dataR%0d", i), rdPort(i), 32'd0);
        check("post_rst_spsr_svc", bus.spsr, 32'd0);
        check("post_rst_err", {31'd0, bus.err}, 32'd0);

        // Randomized traffic against the reference model (state is all zero now)
        mdlReg.delete();
        mdlSpsr.delete();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                do m = 5'($urandom); while (modeName(m) != "");
            end else begin
                m = validModes[$urandom_range(0, 6)];
            end
            bus.mode = m;
            bus.addrR = 12'($urandom);
            bus.regW0 = 1'($urandom); bus.addrW0 = 4'($urandom); bus.dataW0 = $urandom;
            bus.regW1 = 1'($urandom); bus.addrW1 = 4'($urandom_range(0, 3) == 0 ? bus.addrW0 : 4'($urandom));
            bus.dataW1 = $urandom;
            bus.regPC = 1'($urandom); bus.dataPC = $urandom;
            bus.regSPSR = ($urandom_range(0, 3) == 0); bus.dataSPSR = $urandom;
            @(negedge CP);
            for (int i = 0; i < NR; i++) check($sformatf("rnd%0d_dataR%0d", c, i), rdPort(i), expRead(i));
            check($sformatf("rnd%0d_spsr", c), bus.spsr, expSpsr());
            eErr = expErr();
            @(posedge CP);
            mdlCommit();
            #1;
            check($sformatf("rnd%0d_err", c), {31'd0, bus.err}, {31'd0, eErr});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/banked_reg_file.md
BANKED_REG_FILE -- requirements
Module: banked_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of every register, read port and write port.
REQ-002 SHALL have parameter NUM_RD, default 3, legal range 1..4: number of read ports.
REQ-003 SHALL have port CP, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mode, input, 5 bits: current processor mode; selects the register bank.
REQ-006 SHALL have port addrR, input, NUM_RD*4 bits: read addresses, port i in bits [4i+3:4i].
REQ-007 SHALL have port dataR, output, NUM_RD*DATA_W bits: read data, port i in bits [DATA_W*i+DATA_W-1:DATA_W*i].
REQ-008 SHALL have ports addrW0/addrW1, input, 4 bits each: write addresses.
REQ-009 SHALL have ports dataW0/dataW1, input, DATA_W bits each: write data.
REQ-010 SHALL have ports regW0/regW1, input, 1 bit each: write enables.
REQ-011 SHALL have ports dataPC (input, DATA_W bits) and regPC (input, 1 bit): PC update port.
REQ-012 SHALL have ports dataSPSR (input, DATA_W bits), regSPSR (input, 1 bit) and spsr (output, DATA_W bits): SPSR write and read for the current mode.
REQ-013 SHALL have port err, output, 1 bit: registered error flag.

Function
REQ-014 SHALL decode mode as USR=10000, FIQ=10001, IRQ=10010, SVC=10011, ABT=10111, UND=11011, SYS=11111; any other value is invalid.
REQ-015 SHALL hold 31 physical registers: r0-r15 common; FIQ banks r8-r14; IRQ, SVC, ABT and UND each bank r13-r14; USR and SYS share the common set.
REQ-016 SHALL return the mode-mapped register combinationally on each read port; address 15 returns the PC.
REQ-017 SHALL perform writes on the rising edge of CP into the register mapped by the mode present in that cycle.
REQ-018 SHALL let W1 win over W0 when both are enabled to the same address in the same cycle.
REQ-019 SHALL let a W0/W1 write to address 15 win over regPC in the same cycle; otherwise regPC loads dataPC.
REQ-020 SHALL hold one SPSR per FIQ, IRQ, SVC, ABT and UND; spsr outputs the current mode's SPSR and regSPSR writes it.
REQ-021 SHALL output spsr = 0 and ignore regSPSR in USR and SYS modes.
REQ-022 SHALL, for an invalid mode, suppress all W0, W1, PC and SPSR writes and drive every read port and spsr to 0.
REQ-023 SHALL set err on the edge following any cycle with: an invalid mode; regW0 and regW1 both set to the same address; or regSPSR in USR or SYS mode. err SHALL clear on the first edge after a clean cycle.
REQ-024 SHALL add no latency beyond one edge: data written at edge N is readable after edge N.

Reset
REQ-025 SHALL, on a rising edge with reset=1, clear all 31 registers, PC, all SPSRs and err to 0, overriding every write that cycle.
REQ-026 SHALL, while reset is held, drive all dataR to 0 except banked values already cleared, spsr to 0 and err to 0.

Configuration
REQ-027 SHALL implement macro BANKED_RF_BYPASS_EN: when defined, a read port whose mapped register is being written this cycle returns the winning write data combinationally (W1 over W0 over regPC, per REQ-018/019); when undefined, reads return the stored value only.

Verification
REQ-028 SHALL cover: USR mode, W0 writes 123 to r0, then 456 to r8 -> after the edges dataR[0]=123 and dataR[1] (addr 8)=456.
REQ-029 SHALL cover: switch to FIQ after REQ-028, W0 writes 789 to r8 -> FIQ r8 reads 789; back in USR r8 reads 456.
REQ-030 SHALL cover: regPC=1 with dataPC=25 and W0 writing 333 to r15 in the same cycle -> r15 reads 333; the next cycle with regPC only and dataPC=26 -> r15 reads 26.
REQ-031 SHALL cover: mode=11010 with W0 writing 123 to r14 -> no register changes, dataR=0, err=1 one cycle later; a valid mode next cycle -> err=0 after the following edge.
REQ-032 SHALL cover: W0 and W1 both writing r3 (111 and 222) -> r3=222 and err=1 next cycle; with BANKED_RF_BYPASS_EN defined, dataR shows 222 in the write cycle.
REQ-033 SHALL cover: SVC mode, regSPSR with 0x1D3 -> spsr=0x1D3 in SVC, 0 in IRQ; reset pulse -> spsr=0 in SVC.
